// File: rtl/i2c_slave_rx_if.sv
// Byte hand-off and status bundle between i2c_slave_rx and its local consumer.
// With I2C_SLAVE_GENCALL_EN defined the bundle also carries the gencall status bit.
interface i2c_slave_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       addr_match;
  logic       busy;
  logic       rx_overrun;
`ifdef I2C_SLAVE_GENCALL_EN
  logic       gencall;

  modport slave (
    output rx_data, rx_valid, addr_match, busy, rx_overrun, gencall,
    input  rx_ready
  );

  modport master (
    input  rx_data, rx_valid, addr_match, busy, rx_overrun, gencall,
    output rx_ready
  );
`else
  modport slave (
    output rx_data, rx_valid, addr_match, busy, rx_overrun,
    input  rx_ready
  );

  modport master (
    input  rx_data, rx_valid, addr_match, busy, rx_overrun,
    output rx_ready
  );
`endif
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: oversampled SCL/SDA, START/STOP detect, address match, open-drain ACK, valid/ready byte hand-off.
// Define I2C_SLAVE_GENCALL_EN to also ACK the general-call address 8'h00 and drive rx.gencall.
module i2c_slave_rx #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  i2c_slave_rx_if.slave rx
);

  localparam int unsigned     CNT_W     = 4;
  localparam logic [CNT_W-1:0] BYTE_DONE = CNT_W'(8);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_rise_c;
  logic                   scl_fall_c;
  logic                   start_c;
  logic                   stop_c;
  logic                   addr_hit_c;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [7:0]       shift_q;
  logic [7:0]       shift_nxt;
  logic             slot_q;
  logic             slot_nxt;
  logic             ack_q;
  logic             ack_nxt;
  logic             sda_oe;
  logic             sda_oe_nxt;
  logic [7:0]       rx_data_q;
  logic [7:0]       rx_data_nxt;
  logic             rx_valid_q;
  logic             rx_valid_nxt;
  logic             addr_match_q;
  logic             addr_match_nxt;
  logic             busy_q;
  logic             busy_nxt;
  logic             rx_overrun_q;
  logic             rx_overrun_nxt;
`ifdef I2C_SLAVE_GENCALL_EN
  logic             gencall_q;
  logic             gencall_nxt;
`endif

  // Input synchronizers plus one history stage for edge and condition detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise_c = scl_s & ~scl_d;
  assign scl_fall_c = ~scl_s & scl_d;
  assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;

  // shift_q still holds {addr, rw} until the first data bit is shifted in
`ifdef I2C_SLAVE_GENCALL_EN
  assign addr_hit_c = (shift_q == {SLAVE_ADDR, 1'b0}) || (shift_q == 8'h00);
`else
  assign addr_hit_c = (shift_q == {SLAVE_ADDR, 1'b0});
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift_q;
    slot_nxt       = slot_q;
    ack_nxt        = ack_q;
    sda_oe_nxt     = sda_oe;
    rx_data_nxt    = rx_data_q;
    rx_valid_nxt   = rx_valid_q & ~rx.rx_ready;
    addr_match_nxt = addr_match_q;
    busy_nxt       = busy_q;
    rx_overrun_nxt = 1'b0;
`ifdef I2C_SLAVE_GENCALL_EN
    gencall_nxt    = gencall_q;
`endif

    if (start_c) begin
      state_nxt      = ST_ADDR;
      bit_cnt_nxt    = '0;
      slot_nxt       = 1'b0;
      sda_oe_nxt     = 1'b0;
      busy_nxt       = 1'b1;
      addr_match_nxt = 1'b0;
`ifdef I2C_SLAVE_GENCALL_EN
      gencall_nxt    = 1'b0;
`endif
    end else if (stop_c) begin
      state_nxt      = ST_IDLE;
      slot_nxt       = 1'b0;
      sda_oe_nxt     = 1'b0;
      busy_nxt       = 1'b0;
      addr_match_nxt = 1'b0;
`ifdef I2C_SLAVE_GENCALL_EN
      gencall_nxt    = 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          if (bit_cnt == BYTE_DONE) begin
            state_nxt = addr_hit_c ? ST_ADDR_ACK : ST_IGNORE;
          end else if (scl_rise_c) begin
            shift_nxt   = {shift_q[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!slot_q) begin
              sda_oe_nxt = 1'b1;
              slot_nxt   = 1'b1;
`ifdef I2C_SLAVE_GENCALL_EN
              if (shift_q == 8'h00) gencall_nxt = 1'b1;
              else                  addr_match_nxt = 1'b1;
`else
              addr_match_nxt = 1'b1;
`endif
            end else begin
              sda_oe_nxt  = 1'b0;
              slot_nxt    = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = ST_DATA;
            end
          end
        end

        ST_DATA: begin
          // A held byte being accepted this very clk frees the buffer for the new one
          if (bit_cnt == BYTE_DONE) begin
            state_nxt = ST_DATA_ACK;
            if (!rx_valid_q || rx.rx_ready) begin
              rx_data_nxt  = shift_q;
              rx_valid_nxt = 1'b1;
              ack_nxt      = 1'b1;
            end else begin
              rx_overrun_nxt = 1'b1;
              ack_nxt        = 1'b0;
            end
          end else if (scl_rise_c) begin
            shift_nxt   = {shift_q[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end

        ST_DATA_ACK: begin
          if (scl_fall_c) begin
            if (!slot_q) begin
              sda_oe_nxt = ack_q;
              slot_nxt   = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              slot_nxt    = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = ST_DATA;
            end
          end
        end

        ST_IGNORE: begin
        end

        default: begin
          state_nxt  = ST_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt      <= '0;
      shift_q      <= 8'h00;
      slot_q       <= 1'b0;
      ack_q        <= 1'b0;
      sda_oe       <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef I2C_SLAVE_GENCALL_EN
      gencall_q    <= 1'b0;
`endif
    end else begin
      bit_cnt      <= bit_cnt_nxt;
      shift_q      <= shift_nxt;
      slot_q       <= slot_nxt;
      ack_q        <= ack_nxt;
      sda_oe       <= sda_oe_nxt;
      rx_data_q    <= rx_data_nxt;
      rx_valid_q   <= rx_valid_nxt;
      addr_match_q <= addr_match_nxt;
      busy_q       <= busy_nxt;
      rx_overrun_q <= rx_overrun_nxt;
`ifdef I2C_SLAVE_GENCALL_EN
      gencall_q    <= gencall_nxt;
`endif
    end
  end

  assign sda           = sda_oe ? 1'b0 : 1'bz;
  assign rx.rx_data    = rx_data_q;
  assign rx.rx_valid   = rx_valid_q;
  assign rx.addr_match = addr_match_q;
  assign rx.busy       = busy_q;
  assign rx.rx_overrun = rx_overrun_q;
`ifdef I2C_SLAVE_GENCALL_EN
  assign rx.gencall    = gencall_q;
`endif

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, hand-off monitor and a transaction-level reference model.
// Define I2C_SLAVE_GENCALL_EN for both files to cover the general-call path.
module tb_i2c_slave_rx;

  localparam logic [6:0] SLAVE_ADDR = 7'h42;
  localparam int         H          = 8;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic scl       = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_rx_if rxif ();

  i2c_slave_rx #(
    .SLAVE_ADDR (SLAVE_ADDR),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scl(scl),
    .sda(sda),
    .rx (rxif)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Monitor: bytes handed over, cycles with rx_valid high, overrun pulses
  logic [7:0]  got_q[$];
  int unsigned mon_vcyc = 0;
  int unsigned mon_ovr  = 0;

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (rxif.rx_valid && rxif.rx_ready) got_q.push_back(rxif.rx_data);
      if (rxif.rx_valid)   mon_vcyc++;
      if (rxif.rx_overrun) mon_ovr++;
    end
  end

  // Reference model: one-byte buffer between bus and consumer
  bit          mdl_pending = 1'b0;
  logic [7:0]  mdl_byte    = 8'h00;
  logic [7:0]  mdl_last    = 8'h00;
  logic [7:0]  exp_q[$];
  int unsigned exp_ovr     = 0;
  logic [7:0]  tx[4];

  function automatic bit addr_hit(input logic [7:0] a);
    bit hit;
    hit = (a == {SLAVE_ADDR, 1'b0});
`ifdef I2C_SLAVE_GENCALL_EN
    if (a == 8'h00) hit = 1'b1;
`endif
    return hit;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wclk(H);
    scl       = 1'b1; wclk(H);
    m_sda_low = 1'b1; wclk(H);
    scl       = 1'b0; wclk(H);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wclk(H);
    scl       = 1'b1; wclk(H);
    m_sda_low = 1'b0; wclk(H);
  endtask

  task automatic clock_bit(input logic b);
    m_sda_low = ~b; wclk(H);
    scl       = 1'b1; wclk(H);
    scl       = 1'b0; wclk(1);
  endtask

  task automatic ack_slot(output bit acked);
    m_sda_low = 1'b0; wclk(H);
    scl       = 1'b1; wclk(H / 2);
    acked     = (sda === 1'b0);
    wclk(H - H / 2);
    scl       = 1'b0; wclk(1);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acked);
    for (int i = 7; i >= 0; i--) clock_bit(b[i]);
    ack_slot(acked);
  endtask

  task automatic drain();
    rxif.rx_ready = 1'b1;
    if (mdl_pending) begin
      exp_q.push_back(mdl_byte);
      mdl_pending = 1'b0;
    end
    wclk(3);
  endtask

  // One transaction: START/Sr, address, n data bytes from tx[], optional STOP
  task automatic do_xfer(input logic [7:0] a, input int n, input bit rdy, input bit do_stop);
    bit          acked;
    bit          hit;
    bit          exp_a;
    int unsigned v0;
    int unsigned n_acc;
    rxif.rx_ready = rdy;
    if (rdy && mdl_pending) begin
      exp_q.push_back(mdl_byte);
      mdl_pending = 1'b0;
    end
    wclk(2);
    v0    = mon_vcyc;
    n_acc = 0;
    bus_start();
    chk("busy_at_start", 32'(rxif.busy), 32'(1));
    chk("addr_match_at_start", 32'(rxif.addr_match), 32'(0));
    send_byte(a, acked);
    hit = addr_hit(a);
    chk("addr_ack", 32'(acked), 32'(hit));
    chk("addr_match", 32'(rxif.addr_match), 32'(hit && (a != 8'h00)));
`ifdef I2C_SLAVE_GENCALL_EN
    chk("gencall", 32'(rxif.gencall), 32'(hit && (a == 8'h00)));
`endif
    for (int i = 0; i < n; i++) begin
      send_byte(tx[i], acked);
      exp_a = 1'b0;
      if (hit) begin
        if (mdl_pending) begin
          exp_ovr++;
        end else begin
          exp_a    = 1'b1;
          mdl_last = tx[i];
          n_acc++;
          if (rdy) exp_q.push_back(tx[i]);
          else begin
            mdl_pending = 1'b1;
            mdl_byte    = tx[i];
          end
        end
      end
      chk("data_ack", 32'(acked), 32'(exp_a));
      chk("rx_data", 32'(rxif.rx_data), 32'(mdl_last));
      chk("rx_valid", 32'(rxif.rx_valid), 32'(mdl_pending));
      chk("busy_mid", 32'(rxif.busy), 32'(1));
    end
    chk("overrun_count", mon_ovr, exp_ovr);
    if (rdy) chk("valid_cycles", mon_vcyc - v0, n_acc);
    if (do_stop) begin
      bus_stop();
      chk("busy_after_stop", 32'(rxif.busy), 32'(0));
      chk("addr_match_after_stop", 32'(rxif.addr_match), 32'(0));
`ifdef I2C_SLAVE_GENCALL_EN
      chk("gencall_after_stop", 32'(rxif.gencall), 32'(0));
`endif
      chk("rx_data_after_stop", 32'(rxif.rx_data), 32'(mdl_last));
    end
    chk("delivered_count", 32'(got_q.size()), 32'(exp_q.size()));
  endtask

  initial begin
    bit         acked;
    logic [7:0] ab;
    int         sel;
    int         nb;
    bit         rdy;
    bit         stp;

    rxif.rx_ready = 1'b1;
    wclk(3);
    chk("reset_rx_data", 32'(rxif.rx_data), 32'(0));
    chk("reset_rx_valid", 32'(rxif.rx_valid), 32'(0));
    chk("reset_addr_match", 32'(rxif.addr_match), 32'(0));
    chk("reset_busy", 32'(rxif.busy), 32'(0));
    chk("reset_rx_overrun", 32'(rxif.rx_overrun), 32'(0));
    chk("reset_sda_released", 32'(sda), 32'(1));
    rst = 1'b0;
    wclk(4);

    tx[0] = 8'hA5;
    do_xfer(8'h84, 1, 1'b1, 1'b1);

    tx[0] = 8'($urandom);
    tx[1] = 8'($urandom);
    do_xfer(8'h86, 2, 1'b1, 1'b1);

    do_xfer(8'h85, 0, 1'b1, 1'b1);

    tx[0] = 8'h11;
    tx[1] = 8'h22;
    do_xfer(8'h84, 2, 1'b0, 1'b1);
    drain();
    chk("rx_valid_after_ready", 32'(rxif.rx_valid), 32'(0));
    chk("rx_data_held", 32'(rxif.rx_data), 32'(8'h11));

    tx[0] = 8'h3C;
    do_xfer(8'h84, 1, 1'b1, 1'b0);
    tx[0] = 8'hC3;
    do_xfer(8'h84, 1, 1'b1, 1'b1);

    tx[0] = 8'($urandom);
    do_xfer(8'h00, 1, 1'b1, 1'b1);

    for (int k = 0; k < 10; k++) begin
      sel = int'($urandom_range(0, 3));
      if (sel < 2)       ab = 8'h84;
      else if (sel == 2) ab = 8'h85;
      else               ab = 8'($urandom);
      nb  = int'($urandom_range(1, 3));
      rdy = 1'($urandom_range(0, 1));
      stp = (k == 9) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int j = 0; j < nb; j++) tx[j] = 8'($urandom);
      do_xfer(ab, nb, rdy, stp);
    end
    drain();

    // Reset while the slave is pulling SDA low in the address ACK slot
    ab = 8'h84;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(ab[i]);
    m_sda_low = 1'b0; wclk(H);
    scl       = 1'b1; wclk(2);
    chk("ack_before_reset", 32'(sda), 32'(0));
    rst = 1'b1;
    wclk(1);
    chk("rst_sda_released", 32'(sda), 32'(1));
    chk("rst_busy", 32'(rxif.busy), 32'(0));
    chk("rst_addr_match", 32'(rxif.addr_match), 32'(0));
    chk("rst_rx_valid", 32'(rxif.rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rxif.rx_data), 32'(0));
    mdl_last = 8'h00;
    rst = 1'b0;
    wclk(H);
    scl = 1'b0; wclk(1);
    send_byte(8'h84, acked);
    chk("no_ack_without_start", 32'(acked), 32'(0));
    chk("idle_after_reset", 32'(rxif.busy), 32'(0));
    bus_stop();

    tx[0] = 8'($urandom);
    do_xfer(8'h84, 1, 1'b1, 1'b1);

    chk("delivered_total", 32'(got_q.size()), 32'(exp_q.size()));
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < got_q.size(); i++) chk("delivered_byte", 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
